gpr_transfer_sequencer: RTL and testbench
=========================================

Name: gpr_transfer_sequencer

Overview:
- Sequences the four-register GPR group (A, B, C, D), which share one bidirectional main bus and the ALU LHS/RHS operand buses.
- Accepts one register-transfer request at a time and emits the per-register load strobes and active-low bus-assert enables at the correct cycles.
- Guarantees at most one driver on the main bus in any cycle.
- Sits between the instruction decode stage and the GPR group.

Parameters:
- ALU_LATENCY, 1, cycles the ALU needs with operands held before its result is valid; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request; high only in IDLE.
- req_op  input  2  00 MOV, 01 ALU, 10 LDX (external→reg), 11 STX (reg→external).
- req_src_a  input  2  source / LHS register (0=A, 1=B, 2=C, 3=D).
- req_src_b  input  2  RHS register; ALU op only.
- req_dst  input  2  destination register.
- stall  input  1  pipeline hold.
- load  output  4  per-register load strobe, active-high; bit0=A … bit3=D.
- main_assert_n  output  4  per-register main-bus drive enable, active-low.
- lhs_assert_n  output  4  per-register LHS drive enable, active-low.
- rhs_assert_n  output  4  per-register RHS drive enable, active-low.
- alu_oe  output  1  ALU drives its result onto the main bus.
- ext_oe  output  1  external source drives the main bus.
- ext_capture  output  1  external sink latches the main bus.
- done  output  1  one-cycle pulse on a transaction's final cycle.

Behaviour:
- One clock; reset is asynchronous and active-low. rst_n is named as above.
- All outputs are registered. There is no combinational path from inputs to outputs, except req_ready, which is decoded from state.
- Reset values: state=IDLE; load=0; all *_assert_n=4'hF; alu_oe=ext_oe=ext_capture=done=0; req_ready=0 while rst_n is low.
- Accept: a request is accepted at the edge where req_valid && req_ready. Fields are captured into internal registers at that edge; inputs are ignored afterwards.
- States: IDLE, DRIVE, ALU_WAIT, COMMIT.
- Transitions:
  - MOV, LDX, STX: IDLE→DRIVE→COMMIT→IDLE.
  - ALU: IDLE→ALU_WAIT (held ALU_LATENCY cycles)→COMMIT→IDLE.
- Per-op outputs, with accept at edge T:
  - MOV: cycles T+1 and T+2 main_assert_n[src_a]=0. At T+2, load[dst]=1 and done=1.
  - LDX: cycles T+1 and T+2 ext_oe=1. At T+2, load[dst]=1 and done=1.
  - STX: cycles T+1 and T+2 main_assert_n[src_a]=0. At T+2, ext_capture=1 and done=1.
  - ALU: from T+1 through T+ALU_LATENCY+1, lhs_assert_n[src_a]=0 and rhs_assert_n[src_b]=0. In the final (COMMIT) cycle, alu_oe=1, load[dst]=1 and done=1.
- Latency: MOV/LDX/STX complete 2 cycles after accept; ALU completes ALU_LATENCY+1 cycles after accept. A new request can be accepted in the cycle after COMMIT, i.e. no back-to-back overlap.
- src_a==src_b on ALU is legal: the same register drives both LHS and RHS.
- MOV with src_a==dst is a NOP. It returns IDLE→IDLE with no asserts, and done pulses at T+1.
- ALU with dst equal to a source is legal. The load strobe and operand enables fall together when COMMIT exits.
- Bus exclusivity invariant, every cycle:
  - at most one of {any main_assert_n low, alu_oe, ext_oe};
  - load is zero- or one-hot.
- ALU_WAIT uses a 4-bit down-counter loaded with ALU_LATENCY-1; the state exits when the counter reaches 0.
- stall:
  - Honoured in DRIVE and ALU_WAIT: state, counter and all outputs hold.
  - Ignored in COMMIT, so a load/capture/done pulse is never stretched.
  - In IDLE, stall forces req_ready=0.
- Reset mid-transaction: all outputs go inactive immediately (asynchronously); the transaction is dropped and done is never asserted.
- Illegal ALU_LATENCY (0 or >15) is an elaboration error.

Test Plan:
- Reset: hold rst_n=0 → load=0, all assert_n=4'hF, req_ready=0. Release rst_n → req_ready=1 on the first clk.
- MOV B→D (op=00, src_a=1, dst=3), accepted at T:
  - T+1 and T+2: main_assert_n=4'b1101.
  - T+2: load=4'b1000, done=1.
  - T+3: req_ready=1.
- ALU C,A→B with ALU_LATENCY=3, accepted at T:
  - T+1..T+4: lhs_assert_n=4'b1011, rhs_assert_n=4'b1110.
  - T+4: alu_oe=1, load=4'b0010, done=1.
  - Checker confirms bus exclusivity holds on every cycle.
- LDX→A then STX A:
  - LDX: ext_oe high for 2 cycles, load=4'b0001 on the second.
  - STX: main_assert_n=4'b1110 for 2 cycles, ext_capture on the second.
  - Back-to-back requests are accepted only when req_ready=1.
- Stall during MOV A→C: assert stall for 3 cycles in DRIVE → main_assert_n stays 4'b1110 and COMMIT is delayed 3 cycles. Assert stall in COMMIT → load is still a single-cycle pulse.
- Reset mid-ALU: drop rst_n during ALU_WAIT → all outputs go inactive with no clock edge, no done is ever seen, and after release the state is IDLE.

Source files
------------

// File: rtl/gpr_transfer_sequencer.sv
// Sequences register transfers for the four-register GPR group (A..D)
// that shares one main bus and the ALU LHS/RHS operand buses.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   req_valid/ready   request handshake (ready only in IDLE, not stalled)
//   req_op            00 MOV, 01 ALU, 10 LDX, 11 STX
//   req_src_a/src_b   LHS/source and RHS register index
//   req_dst           destination register index
//   stall             holds DRIVE / ALU_WAIT
//   load              per-register load strobe
//   main/lhs/rhs_assert_n  per-register bus drive enables (active-low)
//   alu_oe, ext_oe    ALU / external source drives main bus
//   ext_capture       external sink latches main bus
//   done              pulse on a transaction's final cycle
module gpr_transfer_sequencer #(
  parameter int ALU_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [1:0] req_src_a,
  input  logic [1:0] req_src_b,
  input  logic [1:0] req_dst,
  input  logic       stall,
  output logic [3:0] load,
  output logic [3:0] main_assert_n,
  output logic [3:0] lhs_assert_n,
  output logic [3:0] rhs_assert_n,
  output logic       alu_oe,
  output logic       ext_oe,
  output logic       ext_capture,
  output logic       done
);

  if (ALU_LATENCY < 1 || ALU_LATENCY > 15) begin : g_bad_lat
    $error("ALU_LATENCY must be in 1..15");
  end

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_ALU = 2'b01;
  localparam logic [1:0] OP_LDX = 2'b10;
  localparam logic [1:0] OP_STX = 2'b11;
  localparam logic [3:0] CNT_INIT = 4'(ALU_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_ALU_WAIT,
    S_COMMIT
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic [1:0] src_a_q, src_a_d;
  logic [1:0] src_b_q, src_b_d;
  logic [1:0] dst_q, dst_d;

  logic [3:0] load_q, load_d;
  logic [3:0] main_q, main_d;
  logic [3:0] lhs_q, lhs_d;
  logic [3:0] rhs_q, rhs_d;
  logic       alu_oe_q, alu_oe_d;
  logic       ext_oe_q, ext_oe_d;
  logic       ext_cap_q, ext_cap_d;
  logic       done_q, done_d;

  logic accept;
  logic nop_done;

  assign req_ready = rst_n && (state_q == S_IDLE) && !stall;
  assign accept    = req_valid && req_ready;

  // Next state and captured request fields.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    src_a_d  = src_a_q;
    src_b_d  = src_b_q;
    dst_d    = dst_q;
    nop_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = req_op;
          src_a_d = req_src_a;
          src_b_d = req_src_b;
          dst_d   = req_dst;
          if (req_op == OP_ALU) begin
            state_d = S_ALU_WAIT;
            cnt_d   = CNT_INIT;
          end else if (req_op == OP_MOV &&
                       req_src_a == req_dst) begin
            nop_done = 1'b1;
          end else begin
            state_d = S_DRIVE;
          end
        end
      end
      S_DRIVE: begin
        if (!stall) state_d = S_COMMIT;
      end
      S_ALU_WAIT: begin
        if (!stall) begin
          if (cnt_q == 4'd0) state_d = S_COMMIT;
          else cnt_d = cnt_q - 4'd1;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register
  // in step with the state they belong to.
  always_comb begin
    load_d    = 4'h0;
    main_d    = 4'hF;
    lhs_d     = 4'hF;
    rhs_d     = 4'hF;
    alu_oe_d  = 1'b0;
    ext_oe_d  = 1'b0;
    ext_cap_d = 1'b0;
    done_d    = nop_done;
    if (state_d != S_IDLE) begin
      unique case (op_d)
        OP_MOV, OP_STX: main_d = ~(4'h1 << src_a_d);
        OP_LDX:         ext_oe_d = 1'b1;
        OP_ALU: begin
          lhs_d = ~(4'h1 << src_a_d);
          rhs_d = ~(4'h1 << src_b_d);
        end
        default: ;
      endcase
    end
    if (state_d == S_COMMIT) begin
      done_d = 1'b1;
      if (op_d == OP_STX) ext_cap_d = 1'b1;
      else load_d = 4'h1 << dst_d;
      if (op_d == OP_ALU) alu_oe_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      op_q      <= 2'd0;
      src_a_q   <= 2'd0;
      src_b_q   <= 2'd0;
      dst_q     <= 2'd0;
      load_q    <= 4'h0;
      main_q    <= 4'hF;
      lhs_q     <= 4'hF;
      rhs_q     <= 4'hF;
      alu_oe_q  <= 1'b0;
      ext_oe_q  <= 1'b0;
      ext_cap_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      src_a_q   <= src_a_d;
      src_b_q   <= src_b_d;
      dst_q     <= dst_d;
      load_q    <= load_d;
      main_q    <= main_d;
      lhs_q     <= lhs_d;
      rhs_q     <= rhs_d;
      alu_oe_q  <= alu_oe_d;
      ext_oe_q  <= ext_oe_d;
      ext_cap_q <= ext_cap_d;
      done_q    <= done_d;
    end
  end

  assign load          = load_q;
  assign main_assert_n = main_q;
  assign lhs_assert_n  = lhs_q;
  assign rhs_assert_n  = rhs_q;
  assign alu_oe        = alu_oe_q;
  assign ext_oe        = ext_oe_q;
  assign ext_capture   = ext_cap_q;
  assign done          = done_q;

endmodule

// File: tb/tb_gpr_transfer_sequencer.sv
// Directed bench for gpr_transfer_sequencer (ALU_LATENCY=3):
// reset, MOV, ALU, LDX/STX, stall, NOP MOV and mid-ALU reset.
module tb_gpr_transfer_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [1:0] req_src_a;
  logic [1:0] req_src_b;
  logic [1:0] req_dst;
  logic       stall;
  logic [3:0] load;
  logic [3:0] main_assert_n;
  logic [3:0] lhs_assert_n;
  logic [3:0] rhs_assert_n;
  logic       alu_oe;
  logic       ext_oe;
  logic       ext_capture;
  logic       done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gpr_transfer_sequencer #(.ALU_LATENCY(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_src_a    (req_src_a),
    .req_src_b    (req_src_b),
    .req_dst      (req_dst),
    .stall        (stall),
    .load         (load),
    .main_assert_n(main_assert_n),
    .lhs_assert_n (lhs_assert_n),
    .rhs_assert_n (rhs_assert_n),
    .alu_oe       (alu_oe),
    .ext_oe       (ext_oe),
    .ext_capture  (ext_capture),
    .done         (done)
  );

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] op, input logic [1:0] a,
                     input logic [1:0] b, input logic [1:0] d);
    req_valid = 1'b1;
    req_op    = op;
    req_src_a = a;
    req_src_b = b;
    req_dst   = d;
  endtask

  // Bus exclusivity and one-hot load, checked every cycle.
  always @(negedge clk) begin
    int drv;
    drv = int'(main_assert_n != 4'hF) + int'(alu_oe) + int'(ext_oe);
    chk("excl_bus", 8'(drv <= 1), 8'd1);
    chk("load_1hot", 8'($onehot0(load)), 8'd1);
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_op = 2'd0;
    req_src_a = 2'd0;
    req_src_b = 2'd0;
    req_dst = 2'd0;
    stall = 1'b0;
    #12;
    chk("rst_load", 8'(load), 8'h0);
    chk("rst_main", 8'(main_assert_n), 8'hF);
    chk("rst_lhs", 8'(lhs_assert_n), 8'hF);
    chk("rst_rhs", 8'(rhs_assert_n), 8'hF);
    chk("rst_done", 8'(done), 8'h0);
    chk("rst_rdy", 8'(req_ready), 8'h0);
    rst_n = 1'b1;
    tick();
    chk("rel_rdy", 8'(req_ready), 8'h1);

    // MOV B->D
    req(2'b00, 2'd1, 2'd0, 2'd3);
    tick();
    req_valid = 1'b0;
    chk("mov1_main", 8'(main_assert_n), 8'hD);
    chk("mov1_load", 8'(load), 8'h0);
    chk("mov1_done", 8'(done), 8'h0);
    chk("mov1_rdy", 8'(req_ready), 8'h0);
    tick();
    chk("mov2_main", 8'(main_assert_n), 8'hD);
    chk("mov2_load", 8'(load), 8'h8);
    chk("mov2_done", 8'(done), 8'h1);
    tick();
    chk("mov3_rdy", 8'(req_ready), 8'h1);
    chk("mov3_main", 8'(main_assert_n), 8'hF);
    chk("mov3_done", 8'(done), 8'h0);

    // ALU C,A -> B, latency 3
    req(2'b01, 2'd2, 2'd0, 2'd1);
    tick();
    req_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk("alu_lhs", 8'(lhs_assert_n), 8'hB);
      chk("alu_rhs", 8'(rhs_assert_n), 8'hE);
      chk("alu_oe_w", 8'(alu_oe), 8'h0);
      chk("alu_done_w", 8'(done), 8'h0);
      tick();
    end
    chk("alu4_lhs", 8'(lhs_assert_n), 8'hB);
    chk("alu4_rhs", 8'(rhs_assert_n), 8'hE);
    chk("alu4_oe", 8'(alu_oe), 8'h1);
    chk("alu4_load", 8'(load), 8'h2);
    chk("alu4_done", 8'(done), 8'h1);
    tick();
    chk("alu5_lhs", 8'(lhs_assert_n), 8'hF);
    chk("alu5_load", 8'(load), 8'h0);
    chk("alu5_rdy", 8'(req_ready), 8'h1);

    // LDX -> A, then STX A held valid through COMMIT
    req(2'b10, 2'd0, 2'd0, 2'd0);
    tick();
    chk("ldx1_ext", 8'(ext_oe), 8'h1);
    chk("ldx1_load", 8'(load), 8'h0);
    req(2'b11, 2'd0, 2'd0, 2'd0);
    tick();
    chk("ldx2_ext", 8'(ext_oe), 8'h1);
    chk("ldx2_load", 8'(load), 8'h1);
    chk("ldx2_done", 8'(done), 8'h1);
    chk("ldx2_rdy", 8'(req_ready), 8'h0);
    tick();
    chk("gap_rdy", 8'(req_ready), 8'h1);
    chk("gap_main", 8'(main_assert_n), 8'hF);
    chk("gap_ext", 8'(ext_oe), 8'h0);
    tick();
    req_valid = 1'b0;
    chk("stx1_main", 8'(main_assert_n), 8'hE);
    chk("stx1_cap", 8'(ext_capture), 8'h0);
    tick();
    chk("stx2_main", 8'(main_assert_n), 8'hE);
    chk("stx2_cap", 8'(ext_capture), 8'h1);
    chk("stx2_load", 8'(load), 8'h0);
    chk("stx2_done", 8'(done), 8'h1);
    tick();
    chk("stx3_cap", 8'(ext_capture), 8'h0);

    // MOV A->C with 3-cycle stall in DRIVE, then stall in COMMIT
    req(2'b00, 2'd0, 2'd0, 2'd2);
    tick();
    req_valid = 1'b0;
    chk("stl_main", 8'(main_assert_n), 8'hE);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stl_hold", 8'(main_assert_n), 8'hE);
      chk("stl_load", 8'(load), 8'h0);
      chk("stl_done", 8'(done), 8'h0);
    end
    stall = 1'b0;
    tick();
    chk("stlc_load", 8'(load), 8'h4);
    chk("stlc_done", 8'(done), 8'h1);
    stall = 1'b1;
    tick();
    chk("stlx_load", 8'(load), 8'h0);
    chk("stlx_done", 8'(done), 8'h0);
    chk("stlx_main", 8'(main_assert_n), 8'hF);
    chk("stl_rdy0", 8'(req_ready), 8'h0);
    stall = 1'b0;
    #1;
    chk("stl_rdy1", 8'(req_ready), 8'h1);

    // MOV B->B is a NOP with done at T+1
    req(2'b00, 2'd1, 2'd0, 2'd1);
    tick();
    req_valid = 1'b0;
    chk("nop_done", 8'(done), 8'h1);
    chk("nop_main", 8'(main_assert_n), 8'hF);
    chk("nop_load", 8'(load), 8'h0);
    chk("nop_rdy", 8'(req_ready), 8'h1);
    tick();
    chk("nop_done2", 8'(done), 8'h0);

    // ALU D,D -> A: same register on both operand buses
    req(2'b01, 2'd3, 2'd3, 2'd0);
    tick();
    req_valid = 1'b0;
    chk("dd_lhs", 8'(lhs_assert_n), 8'h7);
    chk("dd_rhs", 8'(rhs_assert_n), 8'h7);
    repeat (3) tick();
    chk("dd_load", 8'(load), 8'h1);
    chk("dd_done", 8'(done), 8'h1);
    tick();

    // Reset during ALU_WAIT
    req(2'b01, 2'd1, 2'd2, 2'd3);
    tick();
    req_valid = 1'b0;
    tick();
    chk("mr_lhs0", 8'(lhs_assert_n), 8'hD);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_lhs", 8'(lhs_assert_n), 8'hF);
    chk("mr_rhs", 8'(rhs_assert_n), 8'hF);
    chk("mr_rdy", 8'(req_ready), 8'h0);
    chk("mr_done", 8'(done), 8'h0);
    tick();
    #2 rst_n = 1'b1;
    #1;
    chk("mr_idle", 8'(req_ready), 8'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mr_nodone", 8'(done), 8'h0);
      chk("mr_noload", 8'(load), 8'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
